syscall_unit: RTL and testbench
===============================

# syscall_unit

Parametrised syscall service block for the single-cycle MIPS core. On each enabled `syscall` it decodes `$v0`, latches `$a0` into the hex display register, queues print requests into an output FIFO for a console/LED consumer, and raises a sticky halt on exit codes. It sits beside the register file. `en` is the decoded `syscall` instruction. `stall` feeds back to the PC-write enable.

## Interface
Parameters:
- `DATA_W`, 32: width of `v0`, `a0`, `hex`, `out_data`, `exit_code`.
- `DEPTH`, 8: output FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the accepted-syscall counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `en`  in  1  syscall instruction present this cycle.
- `v0`  in  DATA_W  service code.
- `a0`  in  DATA_W  argument.
- `stall`  out  1  combinational; core must hold PC and re-present the syscall.
- `halt`  out  1  registered, sticky.
- `exit_code`  out  DATA_W  value of `a0` at exit (0 for code 10).
- `hex`  out  DATA_W  display register.
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  DATA_W  FIFO head.
- `out_ready`  in  1  consumer accepts the head.
- `count`  out  CNT_W  number of accepted syscalls.
- `bad_code`  out  1  sticky; an unsupported code was accepted.

## Operation
- **Accept condition:** a syscall is *accepted* on a rising edge when `en & ~stall & ~halt`.
- **Code decode** (compare full `v0`, zero-extended constants):
  - **1 (print int):** `hex <= a0`; push `a0` into the FIFO.
  - **34 (print hex):** `hex <= a0`; no push.
  - **10 (exit):** `halt <= 1`; `exit_code <= 0`; `hex <= a0`.
  - **17 (exit2):** `halt <= 1`; `exit_code <= a0`; `hex <= a0`.
  - **Any other code:** `hex <= a0`; `bad_code <= 1`; no other effect.
- **Stall:** `stall = en & ~halt & (v0 == 1) & full`. It is never asserted for other codes. It does not consider `out_ready`: there is no same-cycle bypass when full.
- **FIFO:**
  - DEPTH entries, first-word fall-through.
  - `out_valid = ~empty`; `out_data` = head entry.
  - Pop on an edge when `out_valid & out_ready`.
  - Pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the MSB.
  - Push and pop on the same edge are both performed, and occupancy is unchanged.
- **Count:** increments by 1 on each accepted syscall and wraps modulo 2^CNT_W.
- **After halt:**
  - `en` is ignored: no `hex`, FIFO, count or `bad_code` change, and `stall` = 0.
  - The FIFO continues to drain to the consumer.
  - Only reset clears `halt`.
- **State machine (two states):**
  - RUN→HALTED on an accepted code 10 or 17.
  - HALTED→RUN only on reset.

## Timing
- **Reset values** (immediate on reset going low, independent of `clk`):
  - `halt` = 0, `exit_code` = 0, `hex` = 0, `count` = 0, `bad_code` = 0.
  - FIFO empty, so `out_valid` = 0; `out_data` is don't-care while `out_valid` = 0.
  - `stall` is combinational and is 0 whenever `en` = 0 or `v0` ≠ 1.
- **Latency:**
  - `hex`, `halt`, `exit_code`, `count` and `bad_code` change at the accepting edge (1 cycle).
  - A pushed word is visible on `out_data` with `out_valid` = 1 after the accepting edge.
- **Stall timing:**
  - `stall` responds combinationally in the same cycle as `en`, `v0` and full.
  - It deasserts in the cycle after a pop makes room.
  - The re-presented syscall is accepted on the following edge.
- **Reset mid-operation:**
  - Reset asserted while the FIFO is non-empty or halted returns every output to its reset value.
  - Queued data is discarded.
- **Release:** reset deassertion is synchronised by the system. The block performs no accept on the same edge as release.

## Test plan
- **Reset, then print int.** After reset, drive `v0`=1, `a0`=0x12345678, `en`=1 for one edge, with `out_ready`=0.
  - Required: `hex`=0x12345678, `out_valid`=1, `out_data`=0x12345678, `count`=1, `halt`=0.
- **FIFO full and stall.** With `out_ready`=0, issue 8 print ints with `a0` = 1..8, then a 9th with `a0`=9.
  - Required: `stall`=1 while the 9th is presented, `count`=8.
  - Then pulse `out_ready` for one edge: head 1 pops, `stall` goes to 0, and the 9th is accepted on the next edge.
  - Drain in order: 2..9, then `out_valid`=0.
- **Exit variants and post-halt behaviour.**
  - Code 17 with `a0`=0xDEADBEEF: `halt`=1 and `exit_code`=0xDEADBEEF after the edge.
  - A following code 1 with `a0`=0xFEEDFACE: `hex` stays 0xDEADBEEF, `count` unchanged, `stall`=0.
  - After a fresh reset, code 10: `halt`=1 and `exit_code`=0.
- **Print hex and bad code.**
  - Code 34 with `a0`=0xCAFEF00D: `hex`=0xCAFEF00D, no push.
  - Code 5: `bad_code`=1, `hex`=`a0`, `count` incremented.
- **Simultaneous push and pop.** With 3 entries queued and `out_ready`=1, accept a print int with `a0`=0xAA.
  - Required: occupancy stays 3, and order is preserved with 0xAA last.
- **Reset mid-operation and count wrap.**
  - Assert `reset`=0 asynchronously between edges while halted and the FIFO is non-empty: all outputs go to their reset values immediately.
  - With `CNT_W`=4, 17 accepted syscalls give `count`=1.

Source files
------------

// File: rtl/syscall_unit.sv
// syscall_unit: syscall service block for the single-cycle MIPS core.
// It decodes $v0 on an accepted syscall, updates the hex display
// register, queues print-int words into a first-word fall-through FIFO,
// and raises a sticky halt on exit codes.
module syscall_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    output logic              stall,
    output logic              halt,
    output logic [DATA_W-1:0] exit_code,
    output logic [DATA_W-1:0] hex,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              bad_code
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [DATA_W-1:0] CODE_PRINT_INT = DATA_W'(1);
    localparam logic [DATA_W-1:0] CODE_EXIT      = DATA_W'(10);
    localparam logic [DATA_W-1:0] CODE_EXIT2     = DATA_W'(17);
    localparam logic [DATA_W-1:0] CODE_PRINT_HEX = DATA_W'(34);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_r;
    logic                halt_r;
    logic [DATA_W-1:0]   exit_code_r;
    logic [DATA_W-1:0]   hex_r;
    logic [CNT_W-1:0]    count_r;
    logic                bad_code_r;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [AW:0]         wr_ptr_r;
    logic [AW:0]         rd_ptr_r;

    logic                empty_s;
    logic                full_s;
    logic                is_print_s;
    logic                stall_s;
    logic                accept_s;
    logic                push_s;
    logic                pop_s;

    // Occupancy flags: the extra pointer MSB separates full from empty.
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    // A print-int with no room holds the PC; no bypass through out_ready.
    assign is_print_s = (v0 == CODE_PRINT_INT);
    assign stall_s    = en & ~halt_r & is_print_s & full_s;
    assign accept_s   = en & ~stall_s & ~halt_r;
    assign push_s     = accept_s & is_print_s;
    assign pop_s      = ~empty_s & out_ready;

    assign stall      = stall_s;
    assign halt       = halt_r;
    assign exit_code  = exit_code_r;
    assign hex        = hex_r;
    assign count      = count_r;
    assign bad_code   = bad_code_r;
    assign out_valid  = ~empty_s;
    assign out_data   = mem_r[rd_ptr_r[AW-1:0]];

    // FIFO storage: written only on push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= a0;
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    // FIFO pointers: push and pop on the same edge both advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Run/halted state machine with its registered service outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_RUN;
            halt_r      <= 1'b0;
            exit_code_r <= '0;
            hex_r       <= '0;
            count_r     <= '0;
            bad_code_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (accept_s) begin
                        hex_r   <= a0;
                        count_r <= count_r + CNT_W'(1);
                        case (v0)
                            CODE_EXIT: begin
                                state_r     <= ST_HALTED;
                                halt_r      <= 1'b1;
                                exit_code_r <= '0;
                            end
                            CODE_EXIT2: begin
                                state_r     <= ST_HALTED;
                                halt_r      <= 1'b1;
                                exit_code_r <= a0;
                            end
                            CODE_PRINT_INT, CODE_PRINT_HEX: begin
                                bad_code_r <= bad_code_r;
                            end
                            default: begin
                                bad_code_r <= 1'b1;
                            end
                        endcase
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_HALTED: begin
                    halt_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_HALTED;
                    halt_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed self-checking bench for syscall_unit
// (counter narrowed to 4 bits so wrap-around is reachable quickly).
module tb_syscall_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        halt;
    logic [31:0] exit_code;
    logic [31:0] hex;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        bad_code;

    int          chk_cnt;
    int          pass_cnt;

    syscall_unit #(.DATA_W(32), .DEPTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .v0        (v0),
        .a0        (a0),
        .stall     (stall),
        .halt      (halt),
        .exit_code (exit_code),
        .hex       (hex),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .bad_code  (bad_code)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: actual=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sys(input logic [31:0] code, input logic [31:0] arg);
        en = 1'b1;
        v0 = code;
        a0 = arg;
        tick();
        en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_halt"},  32'(halt),      32'h0);
        check({tag, "_exit"},  exit_code,      32'h0);
        check({tag, "_hex"},   hex,            32'h0);
        check({tag, "_count"}, 32'(count),     32'h0);
        check({tag, "_bad"},   32'(bad_code),  32'h0);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        reset     = 1'b0;
        en        = 1'b0;
        v0        = 32'h0;
        a0        = 32'h0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check_reset_vals("rst");
        check("rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Print int after reset
        do_sys(32'd1, 32'h12345678);
        check("pi_hex",   hex,            32'h12345678);
        check("pi_valid", 32'(out_valid), 32'h1);
        check("pi_data",  out_data,       32'h12345678);
        check("pi_count", 32'(count),     32'h1);
        check("pi_halt",  32'(halt),      32'h0);

        // FIFO full and stall
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            do_sys(32'd1, 32'(i));
        end
        en = 1'b1;
        v0 = 32'd1;
        a0 = 32'd9;
        #1;
        check("full_stall", 32'(stall), 32'h1);
        check("full_count", 32'(count), 32'h8);
        v0 = 32'd34;
        #1;
        check("full_nostall_34", 32'(stall), 32'h0);
        v0 = 32'd1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_stall", 32'(stall),  32'h0);
        check("pop_head",  out_data,    32'h2);
        check("pop_count", 32'(count),  32'h8);
        tick();
        en = 1'b0;
        check("ninth_count", 32'(count), 32'h9);
        for (int i = 2; i <= 9; i++) begin
            check("drain_valid", 32'(out_valid), 32'h1);
            check("drain_data",  out_data,       32'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("drain_empty", 32'(out_valid), 32'h0);

        // Exit2 and post-halt behaviour
        do_reset();
        do_sys(32'd17, 32'hDEADBEEF);
        check("ex17_halt", 32'(halt), 32'h1);
        check("ex17_code", exit_code, 32'hDEADBEEF);
        check("ex17_hex",  hex,       32'hDEADBEEF);
        en = 1'b1;
        v0 = 32'd1;
        a0 = 32'hFEEDFACE;
        #1;
        check("halted_stall", 32'(stall), 32'h0);
        tick();
        en = 1'b0;
        check("halted_hex",   hex,            32'hDEADBEEF);
        check("halted_count", 32'(count),     32'h1);
        check("halted_valid", 32'(out_valid), 32'h0);

        // Exit code 10 after fresh reset
        do_reset();
        do_sys(32'd10, 32'h55);
        check("ex10_halt", 32'(halt), 32'h1);
        check("ex10_code", exit_code, 32'h0);
        check("ex10_hex",  hex,       32'h55);

        // Print hex and bad code
        do_reset();
        do_sys(32'd34, 32'hCAFEF00D);
        check("phex_hex",   hex,            32'hCAFEF00D);
        check("phex_valid", 32'(out_valid), 32'h0);
        check("phex_count", 32'(count),     32'h1);
        check("phex_bad",   32'(bad_code),  32'h0);
        do_sys(32'd5, 32'h77);
        check("bad_flag",  32'(bad_code), 32'h1);
        check("bad_hex",   hex,           32'h77);
        check("bad_count", 32'(count),    32'h2);
        check("bad_halt",  32'(halt),     32'h0);

        // Simultaneous push and pop
        do_reset();
        do_sys(32'd1, 32'h11);
        do_sys(32'd1, 32'h22);
        do_sys(32'd1, 32'h33);
        out_ready = 1'b1;
        do_sys(32'd1, 32'hAA);
        out_ready = 1'b0;
        check("pp_count", 32'(count), 32'h4);
        check("pp_d0", out_data, 32'h22);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_d1", out_data, 32'h33);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_d2",    out_data,       32'hAA);
        check("pp_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_empty", 32'(out_valid), 32'h0);

        // Reset mid-operation while halted with queued data
        do_sys(32'd1, 32'h44);
        do_sys(32'd17, 32'h99);
        check("pre_halt",  32'(halt),      32'h1);
        check("pre_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("mid");
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rel_valid", 32'(out_valid), 32'h0);

        // Count wrap with a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            do_sys(32'd34, 32'(i));
        end
        check("wrap16", 32'(count), 32'h0);
        do_sys(32'd34, 32'h16);
        check("wrap17", 32'(count), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
